// File: rtl/cpu_types_pkg.sv
// Shared CPU types; this slice holds the multiply/divide unit opcodes, FSM states and sizing.
package cpu_types_pkg;

    localparam int unsigned MDU_DATA_W = 32;
    localparam int unsigned MDU_ITERS  = MDU_DATA_W;

    typedef enum logic [2:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MTHI  = 3'd4,
        MDU_MTLO  = 3'd5
    } mdu_op_t;

    typedef enum logic [2:0] {
        StIdle,
        StMul,
        StDiv,
        StFix,
        StDone
    } mdu_state_t;

endpackage

// File: rtl/mdu_step.sv
// One combinational multiply/divide iteration on the {upper, lower} accumulator, one shared adder.
module mdu_step #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              is_div,
    input  logic [2*DATA_W:0] acc,
    input  logic [DATA_W-1:0] opnd,
    output logic [2*DATA_W:0] acc_next
);

    logic [DATA_W:0]   x;
    logic [DATA_W:0]   y;
    logic              cin;
    logic [DATA_W+1:0] sum;
    logic [DATA_W:0]   rem_sh;
    logic              no_borrow;

    always_comb begin
        rem_sh = acc[2*DATA_W-1:DATA_W-1];
        if (is_div) begin
            // Trial subtract: rem_sh - divisor as rem_sh + ~divisor + 1
            x   = rem_sh;
            y   = ~{1'b0, opnd};
            cin = 1'b1;
        end else begin
            x   = acc[2*DATA_W:DATA_W];
            y   = acc[0] ? {1'b0, opnd} : '0;
            cin = 1'b0;
        end
        sum       = {1'b0, x} + {1'b0, y} + {{(DATA_W+1){1'b0}}, cin};
        no_borrow = sum[DATA_W+1];
        if (is_div) begin
            acc_next = {(no_borrow ? sum[DATA_W:0] : rem_sh), acc[DATA_W-2:0], no_borrow};
        end else begin
            acc_next = {1'b0, sum[DATA_W:0], acc[DATA_W-1:1]};
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit owning HI/LO; one bit per cycle, sign fix-up in a final FIX cycle.
module mult_div_unit
    import cpu_types_pkg::*;
#(
    parameter int unsigned DATA_W = MDU_DATA_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  mdu_op_t           op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic              div0,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam int unsigned CntW = $clog2(DATA_W);

    mdu_state_t        state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [2*DATA_W:0] acc_q, acc_d, acc_step;
    logic [DATA_W-1:0] opnd_q, opnd_d;
    logic              is_div_q, is_div_d;
    logic              dz_q, dz_d;
    logic              neg_q, neg_d;
    logic              neg_rem_q, neg_rem_d;
    logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;

    logic                signed_op;
    logic                accept;
    logic [DATA_W-1:0]   a_mag, b_mag;
    logic [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]   quo, rem;

    mdu_step #(.DATA_W(DATA_W)) u_step (
        .is_div   (is_div_q),
        .acc      (acc_q),
        .opnd     (opnd_q),
        .acc_next (acc_step)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        is_div_d  = is_div_q;
        dz_d      = dz_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        signed_op = (op == MDU_MULT) || (op == MDU_DIV);
        a_mag     = (signed_op && a[DATA_W-1]) ? -a : a;
        b_mag     = (signed_op && b[DATA_W-1]) ? -b : b;
        accept    = start && ((state_q == StIdle) || (state_q == StDone));

        prod = neg_q ? -acc_q[2*DATA_W-1:0] : acc_q[2*DATA_W-1:0];
        quo  = neg_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
        rem  = neg_rem_q ? -acc_q[2*DATA_W-1:DATA_W] : acc_q[2*DATA_W-1:DATA_W];

        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (accept) begin
                    case (op)
                        MDU_MULT, MDU_MULTU: begin
                            state_d  = StMul;
                            cnt_d    = '0;
                            is_div_d = 1'b0;
                            dz_d     = 1'b0;
                            neg_d    = signed_op && (a[DATA_W-1] ^ b[DATA_W-1]);
                            opnd_d   = a_mag;
                            acc_d    = {{(DATA_W+1){1'b0}}, b_mag};
                        end
                        MDU_DIV, MDU_DIVU: begin
                            cnt_d     = '0;
                            is_div_d  = 1'b1;
                            dz_d      = (b == '0);
                            neg_d     = signed_op && (a[DATA_W-1] ^ b[DATA_W-1]);
                            neg_rem_d = signed_op && a[DATA_W-1];
                            opnd_d    = b_mag;
                            // Divide by zero keeps the raw dividend so FIX can return it in HI
                            acc_d     = {{(DATA_W+1){1'b0}}, (b == '0) ? a : a_mag};
                            state_d   = (b == '0) ? StFix : StDiv;
                        end
                        MDU_MTHI: hi_d = a;
                        MDU_MTLO: lo_d = a;
                        default: ;
                    endcase
                end
            end
            StMul, StDiv: begin
                acc_d = acc_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntW'(DATA_W - 1)) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                state_d = StDone;
                if (!is_div_q) begin
                    {hi_d, lo_d} = prod;
                end else if (dz_q) begin
                    hi_d = acc_q[DATA_W-1:0];
                    lo_d = '1;
                end else begin
                    hi_d = rem;
                    lo_d = quo;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            is_div_q  <= 1'b0;
            dz_q      <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            is_div_q  <= is_div_d;
            dz_q      <= dz_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy = (state_q == StMul) || (state_q == StDiv) || (state_q == StFix);
    assign done = (state_q == StDone);
    assign div0 = done && is_div_q && dz_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed and random bench for mult_div_unit; results checked through an expected-value queue.
module tb_mult_div_unit;
    import cpu_types_pkg::*;

    localparam int unsigned W = 32;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         div0;
    } exp_t;

    logic         CLK = 1'b0;
    logic         RST;
    logic         start;
    mdu_op_t      op;
    logic [W-1:0] a, b;
    logic         busy, done, div0;
    logic [W-1:0] hi, lo;

    exp_t sb_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;

    always #5 CLK = ~CLK;

    mult_div_unit #(.DATA_W(W)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .div0  (div0),
        .hi    (hi),
        .lo    (lo)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input mdu_op_t o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t        e;
        longint      sx, sy;
        logic [63:0] p;
        sx     = longint'($signed(x));
        sy     = longint'($signed(y));
        e.div0 = 1'b0;
        case (o)
            MDU_MULT:  p = 64'(sx * sy);
            MDU_MULTU: p = {32'b0, x} * {32'b0, y};
            MDU_DIV: begin
                if (y == '0) begin p = {x, 32'hFFFF_FFFF}; e.div0 = 1'b1; end
                else p = {32'(sx % sy), 32'(sx / sy)};
            end
            MDU_DIVU: begin
                if (y == '0) begin p = {x, 32'hFFFF_FFFF}; e.div0 = 1'b1; end
                else p = {x % y, x / y};
            end
            default: p = '0;
        endcase
        e.hi = p[63:32];
        e.lo = p[31:0];
        return e;
    endfunction

    // Compare every done pulse against the oldest outstanding expectation
    always @(negedge CLK) begin
        if (done) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_done", 64'(done), 64'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check("sb_hi", 64'(hi), 64'(mon_e.hi));
                check("sb_lo", 64'(lo), 64'(mon_e.lo));
                check("sb_div0", 64'(div0), 64'(mon_e.div0));
            end
        end
    end

    task automatic push(input logic [W-1:0] h, input logic [W-1:0] l, input logic d0);
        exp_t e;
        e.hi   = h;
        e.lo   = l;
        e.div0 = d0;
        sb_q.push_back(e);
    endtask

    // Called at posedge+1; returns at E0+1
    task automatic issue(input mdu_op_t o, input logic [W-1:0] x, input logic [W-1:0] y);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int exp_lat);
        int           n       = 0;
        bit           busy_ok = 1'b1;
        bit           hold_ok = 1'b1;
        logic [W-1:0] h0      = hi;
        logic [W-1:0] l0      = lo;
        while (!done && n < 200) begin
            @(posedge CLK);
            #1;
            n++;
            if (!done) begin
                if (busy !== 1'b1) busy_ok = 1'b0;
                if (hi !== h0 || lo !== l0) hold_ok = 1'b0;
            end
        end
        check({tag, "_latency"}, 64'(n), 64'(exp_lat));
        check({tag, "_busy"}, 64'(busy_ok), 64'd1);
        check({tag, "_hold"}, 64'(hold_ok), 64'd1);
    endtask

    task automatic idle_cycle();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        exp_t    e;
        mdu_op_t ro;
        logic [W-1:0] ra, rb;
        bit      done_seen;

        RST   = 1'b1;
        start = 1'b0;
        op    = MDU_MULTU;
        a     = '0;
        b     = '0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_div0", 64'(div0), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        RST = 1'b0;
        idle_cycle();

        push(32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        issue(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("multu_max", 33);
        idle_cycle();

        push(32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        issue(MDU_MULT, 32'hFFFF_FFFD, 32'd7);
        wait_done("mult_neg", 33);
        idle_cycle();

        push(32'h4000_0000, 32'h0000_0000, 1'b0);
        issue(MDU_MULT, 32'h8000_0000, 32'h8000_0000);
        wait_done("mult_minmin", 33);
        idle_cycle();

        push(32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        issue(MDU_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done("div_neg", 33);
        idle_cycle();

        push(32'h0000_0000, 32'h8000_0000, 1'b0);
        issue(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("div_ovf", 33);
        idle_cycle();

        push(32'd2, 32'd14, 1'b0);
        issue(MDU_DIVU, 32'd100, 32'd7);
        wait_done("divu", 33);
        idle_cycle();

        push(32'd100, 32'hFFFF_FFFF, 1'b1);
        issue(MDU_DIVU, 32'd100, 32'd0);
        wait_done("divu_zero", 1);
        idle_cycle();

        push(32'd2, 32'd14, 1'b0);
        issue(MDU_DIVU, 32'd100, 32'd7);
        wait_done("div0_clears", 33);
        idle_cycle();

        // A start while busy must not disturb the running multiply
        push(32'hFFFF_FFFF, 32'hFFFF_FFD3, 1'b0);
        issue(MDU_MULT, 32'hFFFF_FFFB, 32'd9);
        repeat (5) @(posedge CLK);
        #1;
        issue(MDU_DIV, 32'd50, 32'd3);
        check("ignored_start_busy", 64'(busy), 64'd1);
        wait_done("mult_after_ignored", 27);
        idle_cycle();

        issue(MDU_MULT, 32'h1234, 32'h5678);
        repeat (10) @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_hi", 64'(hi), 64'd0);
        check("abort_lo", 64'(lo), 64'd0);

        push(32'd0, 32'd42, 1'b0);
        issue(MDU_MULTU, 32'd6, 32'd7);
        wait_done("multu_after_rst", 33);
        idle_cycle();

        issue(MDU_MTHI, 32'h1234, 32'd0);
        check("mthi_hi", 64'(hi), 64'h1234);
        check("mthi_busy", 64'(busy), 64'd0);
        issue(MDU_MTLO, 32'h5678, 32'd0);
        check("mtlo_lo", 64'(lo), 64'h5678);
        done_seen = 1'b0;
        repeat (3) begin
            if (done || busy) done_seen = 1'b1;
            idle_cycle();
        end
        check("mtx_no_done", 64'(done_seen), 64'd0);

        issue(mdu_op_t'(3'd7), 32'hDEAD_BEEF, 32'd1);
        check("invalid_busy", 64'(busy), 64'd0);
        check("invalid_hi", 64'(hi), 64'h1234);
        check("invalid_lo", 64'(lo), 64'h5678);
        idle_cycle();

        // Back-to-back: new start accepted in the DONE cycle
        push(32'd2, 32'd14, 1'b0);
        issue(MDU_DIVU, 32'd100, 32'd7);
        wait_done("b2b_first", 33);
        push(32'd0, 32'd391, 1'b0);
        issue(MDU_MULTU, 32'd17, 32'd23);
        check("b2b_busy", 64'(busy), 64'd1);
        wait_done("b2b_second", 33);
        idle_cycle();

        for (int i = 0; i < 8; i++) begin
            ro = mdu_op_t'(3'($urandom_range(0, 3)));
            ra = $urandom();
            rb = (i == 5) ? 32'd0 : $urandom();
            if (i == 2) rb = rb >> 20;
            e = model(ro, ra, rb);
            sb_q.push_back(e);
            issue(ro, ra, rb);
            wait_done("random", e.div0 ? 1 : 33);
            idle_cycle();
        end

        idle_cycle();
        check("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
